// File: rtl/mux2_1_arbiter.sv
// mux2_1_arbiter: shares the select of a 2:1 single-bit mux between two
// requesters using round-robin arbitration with a bounded hold time.
//
// Ports:
//   sys_clk, sys_rst_n : clock (rising edge), async active-low reset
//   req_1, req_2       : level-sensitive requests
//   in_1, in_2         : requester data
//   gnt_1, gnt_2       : current owner of the mux (mutually exclusive)
//   sel                : registered select, 1 routes in_1, 0 routes in_2
//   out, out_valid     : registered mux result and its valid flag
//
// Build option: define MUX2_1_ARB_FIXED_PRIO_EN to favour requester 1
// (ties go to 1 and requester 1 is never force-rotated).
module mux2_1_arbiter #(
    parameter int MAX_HOLD = 8
) (
    input  logic sys_clk,
    input  logic sys_rst_n,
    input  logic req_1,
    input  logic req_2,
    input  logic in_1,
    input  logic in_2,
    output logic gnt_1,
    output logic gnt_2,
    output logic sel,
    output logic out,
    output logic out_valid
);

    localparam int CW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
    localparam logic [CW-1:0] HOLD_LAST = CW'(MAX_HOLD - 1);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] GNT_1 = 2'd1;
    localparam logic [1:0] GNT_2 = 2'd2;

    localparam logic LAST_1 = 1'b0;
    localparam logic LAST_2 = 1'b1;

    logic [1:0]    state_q, state_d;
    logic          last_q, last_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          sel_q, sel_d;
    logic          out_q, valid_q;

    logic at_limit;
    logic rot_1;
    logic rot_2;
    logic tie_to_1;

    assign at_limit = (cnt_q == HOLD_LAST);
    assign rot_2    = at_limit;

`ifdef MUX2_1_ARB_FIXED_PRIO_EN
    assign rot_1    = 1'b0;
    assign tie_to_1 = 1'b1;
`else
    assign rot_1    = at_limit;
    assign tie_to_1 = (last_q == LAST_2);
`endif

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (req_1 && (!req_2 || tie_to_1))
                    state_d = GNT_1;
                else if (req_2)
                    state_d = GNT_2;
            end
            GNT_1: begin
                // Handover goes straight to the other grant, no idle bubble.
                if (!req_1)
                    state_d = req_2 ? GNT_2 : IDLE;
                else if (req_2 && rot_1)
                    state_d = GNT_2;
            end
            GNT_2: begin
                if (!req_2)
                    state_d = req_1 ? GNT_1 : IDLE;
                else if (req_1 && rot_2)
                    state_d = GNT_1;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        cnt_d  = cnt_q;
        last_d = last_q;
        sel_d  = sel_q;
        // Counter restarts on every state change and saturates otherwise.
        if (state_d != state_q)
            cnt_d = '0;
        else if (state_q != IDLE && !at_limit)
            cnt_d = cnt_q + CW'(1);
        if (state_d == GNT_1) begin
            last_d = LAST_1;
            sel_d  = 1'b1;
        end else if (state_d == GNT_2) begin
            last_d = LAST_2;
            sel_d  = 1'b0;
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q <= IDLE;
            last_q  <= LAST_2;
            cnt_q   <= '0;
            sel_q   <= 1'b1;
            out_q   <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
            sel_q   <= sel_d;
            out_q   <= sel_q ? in_1 : in_2;
            valid_q <= (state_q == GNT_1) || (state_q == GNT_2);
        end
    end

    assign gnt_1     = (state_q == GNT_1);
    assign gnt_2     = (state_q == GNT_2);
    assign sel       = sel_q;
    assign out       = out_q;
    assign out_valid = valid_q;

endmodule

// File: tb/tb_mux2_1_arbiter.sv
// tb_mux2_1_arbiter: scenario tasks for the 2:1 mux arbiter, MAX_HOLD=4.
// Expected outputs are queued when stimulus is driven, compared after the edge.
module tb_mux2_1_arbiter;

    localparam int MH = 4;

    logic sys_clk   = 1'b0;
    logic sys_rst_n = 1'b0;
    logic req_1 = 1'b0;
    logic req_2 = 1'b0;
    logic in_1  = 1'b0;
    logic in_2  = 1'b0;
    logic gnt_1, gnt_2, sel, out, out_valid;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct packed {
        logic g1;
        logic g2;
        logic sel;
        logic out;
        logic ov;
    } exp_t;

    exp_t exp_q[$];
    exp_t e;
    logic sel_m = 1'b1;
    logic gv_m  = 1'b0;

    mux2_1_arbiter #(.MAX_HOLD(MH)) dut (
        .sys_clk  (sys_clk),
        .sys_rst_n(sys_rst_n),
        .req_1    (req_1),
        .req_2    (req_2),
        .in_1     (in_1),
        .in_2     (in_2),
        .gnt_1    (gnt_1),
        .gnt_2    (gnt_2),
        .sel      (sel),
        .out      (out),
        .out_valid(out_valid)
    );

    always #5 sys_clk = ~sys_clk;

    // Drive one cycle of stimulus and queue what must be seen after the edge:
    // the given grant/sel, data routed by the select held before the edge,
    // and valid equal to whether a grant was held before the edge.
    task automatic drive(input logic r1, input logic r2,
                         input logic g1e, input logic g2e, input logic se);
        exp_t x;
        @(negedge sys_clk);
        req_1 = r1;
        req_2 = r2;
        in_1  = 1'($urandom_range(0, 1));
        in_2  = 1'($urandom_range(0, 1));
        x.g1  = g1e;
        x.g2  = g2e;
        x.sel = se;
        x.out = sel_m ? in_1 : in_2;
        x.ov  = gv_m;
        exp_q.push_back(x);
        sel_m = se;
        gv_m  = g1e | g2e;
        @(posedge sys_clk);
        #1;
    endtask

    task automatic do_reset();
        req_1 = 1'b0;
        req_2 = 1'b0;
        sys_rst_n = 1'b0;
        sel_m = 1'b1;
        gv_m  = 1'b0;
        exp_q.delete();
        repeat (2) @(posedge sys_clk);
        #2 sys_rst_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
        void'(exp_q.pop_front());
        drive(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        void'(exp_q.pop_front());
        #2;
        req_1 = 1'($urandom_range(0, 1));
        req_2 = 1'($urandom_range(0, 1));
        in_1  = 1'b1;
        in_2  = 1'b1;
        sys_rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({gnt_1, gnt_2, sel, out, out_valid} !== 5'b00100) begin
            n_err++;
            $display("FAIL reset_async: got g1g2 sel out ov=%b%b %b %b %b want 00 1 0 0",
                     gnt_1, gnt_2, sel, out, out_valid);
        end
    endtask

    task automatic test_single();
        do_reset();
        for (int k = 0; k < 20; k++) begin
            drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
            e = exp_q.pop_front();
            n_cmp++;
            if ({gnt_1, gnt_2, sel, out & e.ov, out_valid} !==
                {e.g1, e.g2, e.sel, e.out & e.ov, e.ov}) begin
                n_err++;
                $display("FAIL single[%0d]: got %b%b%b%b%b want %b%b%b%b%b", k,
                         gnt_1, gnt_2, sel, out, out_valid,
                         e.g1, e.g2, e.sel, e.out, e.ov);
            end
        end
    endtask

    task automatic test_tie();
        logic g;
        do_reset();
        for (int k = 0; k < 12; k++) begin
            g = ((k / MH) % 2) == 0;
            drive(1'b1, 1'b1, g, !g, g);
            e = exp_q.pop_front();
            n_cmp++;
            if ({gnt_1, gnt_2, sel, out & e.ov, out_valid} !==
                {e.g1, e.g2, e.sel, e.out & e.ov, e.ov}) begin
                n_err++;
                $display("FAIL tie[%0d]: got %b%b%b%b%b want %b%b%b%b%b", k,
                         gnt_1, gnt_2, sel, out, out_valid,
                         e.g1, e.g2, e.sel, e.out, e.ov);
            end
        end
    endtask

    task automatic test_handover();
        do_reset();
        for (int k = 0; k < 9; k++) begin
            if (k < 3)
                drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
            else if (k < 7)
                drive(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
            else
                drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
            e = exp_q.pop_front();
            n_cmp++;
            if ({gnt_1, gnt_2, sel, out & e.ov, out_valid} !==
                {e.g1, e.g2, e.sel, e.out & e.ov, e.ov}) begin
                n_err++;
                $display("FAIL handover[%0d]: got %b%b%b%b%b want %b%b%b%b%b", k,
                         gnt_1, gnt_2, sel, out, out_valid,
                         e.g1, e.g2, e.sel, e.out, e.ov);
            end
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        for (int k = 0; k < MH; k++) begin
            drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
            void'(exp_q.pop_front());
        end
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
            void'(exp_q.pop_front());
        end
        n_cmp++;
        if (gnt_2 !== 1'b1) begin
            n_err++;
            $display("FAIL mid_pre: got gnt_2=%b want 1", gnt_2);
        end
        #2;
        in_1 = 1'b1;
        in_2 = 1'b1;
        sys_rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({gnt_1, gnt_2, sel, out, out_valid} !== 5'b00100) begin
            n_err++;
            $display("FAIL mid_reset: got g1g2 sel out ov=%b%b %b %b %b want 00 1 0 0",
                     gnt_1, gnt_2, sel, out, out_valid);
        end
        sel_m = 1'b1;
        gv_m  = 1'b0;
        exp_q.delete();
        @(posedge sys_clk);
        #2 sys_rst_n = 1'b1;
        for (int k = 0; k < 2; k++) begin
            drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
            e = exp_q.pop_front();
            n_cmp++;
            if ({gnt_1, gnt_2, sel, out & e.ov, out_valid} !==
                {e.g1, e.g2, e.sel, e.out & e.ov, e.ov}) begin
                n_err++;
                $display("FAIL mid_after[%0d]: got %b%b%b%b%b want %b%b%b%b%b", k,
                         gnt_1, gnt_2, sel, out, out_valid,
                         e.g1, e.g2, e.sel, e.out, e.ov);
            end
        end
    endtask

    task automatic test_fixed_prio();
        do_reset();
        for (int k = 0; k < 16; k++) begin
            if (k < 10)
                drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
            else if (k == 10)
                drive(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
            else if (k < 14)
                drive(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
            else
                drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
            e = exp_q.pop_front();
            n_cmp++;
            if ({gnt_1, gnt_2, sel, out & e.ov, out_valid} !==
                {e.g1, e.g2, e.sel, e.out & e.ov, e.ov}) begin
                n_err++;
                $display("FAIL fixed[%0d]: got %b%b%b%b%b want %b%b%b%b%b", k,
                         gnt_1, gnt_2, sel, out, out_valid,
                         e.g1, e.g2, e.sel, e.out, e.ov);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_handover();
`ifdef MUX2_1_ARB_FIXED_PRIO_EN
        test_fixed_prio();
`else
        test_tie();
        test_reset_mid();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
